stack_param: RTL and testbench
==============================

# stack_param

Parametrised successor to the fixed 4-bit, 5-entry behavioural stack. It provides a LIFO of `DEPTH` words of `WIDTH` bits and keeps the same four-command interface: NOP, PUSH, POP, GET. It adds occupancy flags, an error strobe and a selectable overflow/underflow policy. It serves as the general stack primitive for the datapath labs, with `WRAP=1` reproducing the legacy circular behaviour.

## Interface
- `WIDTH`, 4, data word width (≥1)
- `DEPTH`, 5, number of entries (≥2; need not be a power of two)
- `WRAP`, 1, overflow/underflow policy: 1 = circular (legacy), 0 = saturating with error
- `CLK` input 1 — single clock; all state updates on the rising edge
- `RESET` input 1 — asynchronous, active-high; clears all state immediately
- `COMMAND` input 2 — operation: 00 NOP, 01 PUSH, 10 POP, 11 GET
- `INDEX` input IW=$clog2(DEPTH) — GET offset from the top (0 = top)
- `I_DATA` input WIDTH — PUSH data
- `O_DATA` output WIDTH — registered result of the last POP/GET
- `O_VALID` output 1 — high for one cycle after a successful POP/GET
- `COUNT` output CW=$clog2(DEPTH+1) — number of valid entries
- `FULL` output 1 — COUNT==DEPTH
- `EMPTY` output 1 — COUNT==0
- `ERROR` output 1 — one-cycle strobe on an illegal operation

## Operation
- State: `mem[DEPTH]`, `sp` (next free slot, 0..DEPTH-1) and `cnt` (0..DEPTH).
- All pointer arithmetic is explicitly modulo `DEPTH`: `dec(x) = (x==0) ? DEPTH-1 : x-1`. Bit truncation is never used, because DEPTH may not be a power of two.
- Top of stack is `dec(sp)`. GET address is `(sp-1-INDEX) mod DEPTH`, computed in CW+1 bits before the modulo reduction.
- **NOP:** no state change. O_DATA holds its value; O_VALID=0; ERROR=0.
- **PUSH, not full:** `mem[sp]<=I_DATA`; sp increments mod DEPTH; cnt+1.
- **PUSH, full, WRAP=1:** the write still occurs, overwriting the oldest entry. sp advances; cnt stays DEPTH; no ERROR.
- **PUSH, full, WRAP=0:** no write, no pointer move; ERROR=1.
- **POP, not empty:** O_DATA<=mem[dec(sp)]; sp<=dec(sp); cnt-1; O_VALID=1.
- **POP, empty, WRAP=1:** O_DATA<=mem[dec(sp)]; sp<=dec(sp) (legacy circular read); cnt stays 0; O_VALID=1; no ERROR.
- **POP, empty, WRAP=0:** O_DATA<=0; no pointer move; ERROR=1; O_VALID=0.
- **GET:** no change to sp or cnt.
  - INDEX<cnt, or WRAP=1: O_DATA<=mem[addr]; O_VALID=1.
  - Otherwise, or INDEX≥DEPTH: O_DATA<=0; ERROR=1; O_VALID=0.
- Only one command executes per cycle, so PUSH and POP can never coincide.

## Timing
- **Reset:** asserting RESET clears all of the following immediately and asynchronously, regardless of CLK or COMMAND:
  - mem all zeros, sp=0, cnt=0
  - O_DATA=0, O_VALID=0, ERROR=0
  - COUNT=0, FULL=0, EMPTY=1
- **While RESET is high:** all commands are ignored.
- **First command after reset:** the first command sampled is the one at the first rising edge after RESET deasserts.
- **Result latency:** 1 cycle. The result of a command sampled at edge N is on O_DATA/O_VALID/ERROR after edge N, and stays until edge N+1.
- **Strobes:** O_VALID and ERROR are registered one-cycle strobes. They are never both high.
- **Flags:** COUNT, FULL and EMPTY are combinational decodes of registered cnt. They update after the edge that executes PUSH/POP.
- **Back-to-back commands:** legal every cycle. A GET immediately after a PUSH sees the new top.
- **Reset mid-operation:** an operation in flight is discarded. No partial write survives.

## Structure
- **Shared package `stack_pkg`:**
  - command encodings CMD_NOP/CMD_PUSH/CMD_POP/CMD_GET as a 2-bit enum
  - policy constants POLICY_SAT=0 and POLICY_WRAP=1
  - function `mod_dec(ptr, depth)`
- **Sub-module `stack_regfile`:**
  - DEPTH×WIDTH storage with one synchronous write port and one combinational read port
  - asynchronous clear on RESET
- **Top level:** holds sp, cnt, the command decode and the output registers.

## Test plan
- **Basic push/get:** Reset; PUSH 0x1, PUSH 0x3; GET 0, 1 → O_DATA 0x3 then 0x1, O_VALID=1, COUNT=2.
- **Wrap overflow:** WRAP=1: PUSH 0x1..0x7 → COUNT=5, FULL=1, no ERROR. GET 0..4 → 0x7, 0x6, 0x5, 0x4, 0x3.
- **Saturating overflow:** WRAP=0: PUSH 0x1..0x6 → the 6th PUSH gives ERROR=1 for one cycle, COUNT stays 5, and GET 0 → 0x5.
- **Saturating underflow and bad GET:** WRAP=0 after reset:
  - POP → ERROR=1, O_DATA=0, EMPTY stays 1.
  - PUSH 0xA, then GET 1 → ERROR=1, O_DATA=0, COUNT=1.
- **Circular pop past empty:** WRAP=1 (non-power-of-two wrap): PUSH 0x1..0x6, then POP ×6 → 0x6, 0x5, 0x4, 0x3, 0x2, then 0x6 again. COUNT goes 4, 3, 2, 1, 0, 0; EMPTY=1; no ERROR.
- **Asynchronous reset mid-operation:**
  - Fill 3 entries.
  - Raise RESET between edges while COMMAND=PUSH → COUNT=0, EMPTY=1, O_DATA=0 with no clock edge.
  - After release, with WRAP=1: PUSH 0x6, then GET 0 → 0x6, COUNT=1.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised LIFO stack: command encodings,
// overflow/underflow policy constants and modulo pointer helpers.
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_e;

    localparam bit POLICY_SAT  = 1'b0;
    localparam bit POLICY_WRAP = 1'b1;

    // Decrement modulo depth; depth need not be a power of two, so the
    // wrap is an explicit compare rather than bit truncation.
    function automatic int mod_dec(input int ptr, input int depth);
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

    // Increment modulo depth, same reasoning as mod_dec.
    function automatic int mod_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH storage for the stack: one synchronous write port, one
// combinational read port, cleared asynchronously on reset.
module stack_regfile #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array: whole array cleared on reset, single write per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read; callers only present addresses below DEPTH.
    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_param.sv
// Parametrised LIFO stack with NOP/PUSH/POP/GET commands, occupancy flags,
// an error strobe and a selectable circular or saturating policy.
// Results of a command sampled on edge N appear after edge N and hold for
// one cycle; O_VALID and ERROR are one-cycle strobes, never both high.
module stack_param
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter bit WRAP  = 1'b1,
    localparam int IW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       COMMAND,
    input  logic [IW-1:0]    INDEX,
    input  logic [WIDTH-1:0] I_DATA,
    output logic [WIDTH-1:0] O_DATA,
    output logic             O_VALID,
    output logic [CW-1:0]    COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ERROR
);

    localparam int DW = CW + 1;

    cmd_e             cmd;
    logic [IW-1:0]    sp, sp_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IW-1:0]    top;
    logic [DW-1:0]    get_diff;
    logic [IW-1:0]    get_addr;
    logic             get_ok;
    logic             we;
    logic [IW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] data_n;
    logic             valid_n;
    logic             err_n;

    assign cmd = cmd_e'(COMMAND);
    assign top = IW'(mod_dec(int'(sp), DEPTH));

    // GET address (sp-1-INDEX) mod DEPTH, formed in CW+1 bits; for any legal
    // INDEX the sum lies in [0, 2*DEPTH-2], so one conditional subtract suffices.
    always_comb begin
        get_diff = DW'(sp) + DW'(DEPTH - 1) - DW'(INDEX);
        get_addr = (get_diff >= DW'(DEPTH)) ? IW'(get_diff - DW'(DEPTH)) : IW'(get_diff);
        get_ok   = (32'(INDEX) < DEPTH) && ((CW'(INDEX) < cnt) || (WRAP == POLICY_WRAP));
    end

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (IW)
    ) u_regfile (
        .clk   (CLK),
        .rst   (RESET),
        .we    (we),
        .waddr (sp),
        .wdata (I_DATA),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Command decode: next pointer, count, write enable and result values.
    always_comb begin
        sp_n    = sp;
        cnt_n   = cnt;
        we      = 1'b0;
        raddr   = top;
        data_n  = O_DATA;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (cmd)
            CMD_PUSH: begin
                if (!FULL || (WRAP == POLICY_WRAP)) begin
                    // When full in circular mode this overwrites the oldest entry.
                    we   = 1'b1;
                    sp_n = IW'(mod_inc(int'(sp), DEPTH));
                    if (!FULL) cnt_n = cnt + CW'(1);
                end else begin
                    err_n = 1'b1;
                end
            end
            CMD_POP: begin
                if (!EMPTY || (WRAP == POLICY_WRAP)) begin
                    // Circular mode keeps reading backwards past empty.
                    data_n  = rdata;
                    sp_n    = top;
                    valid_n = 1'b1;
                    if (!EMPTY) cnt_n = cnt - CW'(1);
                end else begin
                    data_n = '0;
                    err_n  = 1'b1;
                end
            end
            CMD_GET: begin
                if (get_ok) begin
                    raddr   = get_addr;
                    data_n  = rdata;
                    valid_n = 1'b1;
                end else begin
                    data_n = '0;
                    err_n  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pointer, count and result registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sp      <= '0;
            cnt     <= '0;
            O_DATA  <= '0;
            O_VALID <= 1'b0;
            ERROR   <= 1'b0;
        end else begin
            sp      <= sp_n;
            cnt     <= cnt_n;
            O_DATA  <= data_n;
            O_VALID <= valid_n;
            ERROR   <= err_n;
        end
    end

    assign COUNT = cnt;
    assign FULL  = (cnt == CW'(DEPTH));
    assign EMPTY = (cnt == '0);

endmodule

// File: tb/tb_stack_param.sv
// Bench for stack_param: a saturating and a circular instance share the same
// stimulus and are compared against an independent LIFO model of each policy.
module tb_stack_param;

    localparam int D = 5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] command;
    logic [2:0] index;
    logic [3:0] i_data;

    logic [3:0] s_odata, w_odata;
    logic       s_valid, w_valid, s_full, w_full, s_empty, w_empty, s_err, w_err;
    logic [2:0] s_count, w_count;

    stack_param #(.WIDTH(4), .DEPTH(D), .WRAP(1'b0)) dut_sat (
        .CLK(clk), .RESET(rst), .COMMAND(command), .INDEX(index), .I_DATA(i_data),
        .O_DATA(s_odata), .O_VALID(s_valid), .COUNT(s_count), .FULL(s_full),
        .EMPTY(s_empty), .ERROR(s_err)
    );

    stack_param #(.WIDTH(4), .DEPTH(D), .WRAP(1'b1)) dut_wrap (
        .CLK(clk), .RESET(rst), .COMMAND(command), .INDEX(index), .I_DATA(i_data),
        .O_DATA(w_odata), .O_VALID(w_valid), .COUNT(w_count), .FULL(w_full),
        .EMPTY(w_empty), .ERROR(w_err)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference models ----------------
    // Saturating stack: a plain LIFO queue.
    logic [3:0] sq[$];
    logic [3:0] sat_data;
    logic       sat_valid, sat_err;
    // Circular stack: ring of D slots with a next-free index.
    logic [3:0] w_mem[D];
    int         w_sp, w_cnt;
    logic [3:0] wr_data;
    logic       wr_valid, wr_err;

    task automatic model_reset();
        sq.delete();
        sat_data = '0; sat_valid = 1'b0; sat_err = 1'b0;
        for (int i = 0; i < D; i++) w_mem[i] = '0;
        w_sp = 0; w_cnt = 0;
        wr_data = '0; wr_valid = 1'b0; wr_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [1:0] c, input logic [2:0] ix, input logic [3:0] d);
        int idx;
        idx = int'(ix);
        sat_valid = 1'b0; sat_err = 1'b0;
        wr_valid  = 1'b0; wr_err  = 1'b0;
        case (c)
            2'b01: begin
                if (sq.size() < D) sq.push_back(d);
                else sat_err = 1'b1;
                w_mem[w_sp] = d;
                w_sp = (w_sp + 1) % D;
                if (w_cnt < D) w_cnt++;
            end
            2'b10: begin
                if (sq.size() > 0) begin
                    sat_data = sq.pop_back();
                    sat_valid = 1'b1;
                end else begin
                    sat_data = '0;
                    sat_err = 1'b1;
                end
                w_sp = (w_sp + D - 1) % D;
                wr_data = w_mem[w_sp];
                wr_valid = 1'b1;
                if (w_cnt > 0) w_cnt--;
            end
            2'b11: begin
                if (idx < sq.size()) begin
                    sat_data = sq[sq.size() - 1 - idx];
                    sat_valid = 1'b1;
                end else begin
                    sat_data = '0;
                    sat_err = 1'b1;
                end
                if (idx < D) begin
                    wr_data = w_mem[(w_sp + D - 1 - idx) % D];
                    wr_valid = 1'b1;
                end else begin
                    wr_data = '0;
                    wr_err = 1'b1;
                end
            end
            default: ;
        endcase
        exp_q.push_back(sat_data);
        exp_q.push_back(wr_data);
    endtask

    task automatic compare_all();
        logic [3:0] e;
        e = exp_q.pop_front();
        check("sat_data",  32'(s_odata), 32'(e));
        check("sat_valid", 32'(s_valid), 32'(sat_valid));
        check("sat_err",   32'(s_err),   32'(sat_err));
        check("sat_count", 32'(s_count), 32'(sq.size()));
        check("sat_full",  32'(s_full),  32'(sq.size() == D));
        check("sat_empty", 32'(s_empty), 32'(sq.size() == 0));
        check("sat_excl",  32'(s_valid & s_err), 32'(0));
        e = exp_q.pop_front();
        check("wrap_data",  32'(w_odata), 32'(e));
        check("wrap_valid", 32'(w_valid), 32'(wr_valid));
        check("wrap_err",   32'(w_err),   32'(wr_err));
        check("wrap_count", 32'(w_count), 32'(w_cnt));
        check("wrap_full",  32'(w_full),  32'(w_cnt == D));
        check("wrap_empty", 32'(w_empty), 32'(w_cnt == 0));
        check("wrap_excl",  32'(w_valid & w_err), 32'(0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sat_count"},  32'(s_count), 32'(0));
        check({tag, "_sat_empty"},  32'(s_empty), 32'(1));
        check({tag, "_sat_full"},   32'(s_full),  32'(0));
        check({tag, "_sat_data"},   32'(s_odata), 32'(0));
        check({tag, "_sat_strb"},   32'({s_valid, s_err}), 32'(0));
        check({tag, "_wrap_count"}, 32'(w_count), 32'(0));
        check({tag, "_wrap_empty"}, 32'(w_empty), 32'(1));
        check({tag, "_wrap_full"},  32'(w_full),  32'(0));
        check({tag, "_wrap_data"},  32'(w_odata), 32'(0));
        check({tag, "_wrap_strb"},  32'({w_valid, w_err}), 32'(0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [1:0] c, input logic [2:0] ix, input logic [3:0] d);
        @(negedge clk);
        command = c; index = ix; i_data = d;
        model_step(c, ix, d);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        command = 2'b00;
        #1;
        model_reset();
        check_reset_state({tag, "_async"});
        @(posedge clk);
        #1;
        check_reset_state({tag, "_held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; command = 2'b00; index = '0; i_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Basic push/get.
        step(2'b01, 3'd0, 4'h1);
        step(2'b01, 3'd0, 4'h3);
        step(2'b11, 3'd0, 4'h0);
        check("plan_get0", 32'(w_odata), 32'h3);
        step(2'b11, 3'd1, 4'h0);
        check("plan_get1", 32'(w_odata), 32'h1);
        check("plan_count2", 32'(w_count), 32'd2);

        // Overflow: circular overwrites, saturating errors on 6th/7th push.
        apply_reset("ovf");
        for (int v = 1; v <= 7; v++) step(2'b01, 3'd0, 4'(v));
        for (int g = 0; g < D; g++) begin
            step(2'b11, 3'(g), 4'h0);
            check("plan_wrap_get", 32'(w_odata), 32'(7 - g));
            if (g == 0) check("plan_sat_get0", 32'(s_odata), 32'h5);
        end

        // Underflow and out-of-range GET.
        apply_reset("udf");
        step(2'b10, 3'd0, 4'h0);
        check("plan_sat_pop_err", 32'(s_err), 32'd1);
        step(2'b01, 3'd0, 4'hA);
        step(2'b11, 3'd1, 4'h0);
        check("plan_sat_get1_err", 32'(s_err), 32'd1);
        step(2'b11, 3'd6, 4'h0);

        // Circular pop past empty.
        apply_reset("cpop");
        for (int v = 1; v <= 6; v++) step(2'b01, 3'd0, 4'(v));
        for (int p = 0; p < 6; p++) step(2'b10, 3'd0, 4'h0);
        check("plan_wrap_pop6", 32'(w_odata), 32'h6);

        // Asynchronous reset between edges with a PUSH pending.
        apply_reset("pre_async");
        for (int v = 1; v <= 3; v++) step(2'b01, 3'd0, 4'(v + 8));
        @(negedge clk);
        command = 2'b01; i_data = 4'h5;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_state("midop");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        command = 2'b00;
        step(2'b01, 3'd0, 4'h6);
        step(2'b11, 3'd0, 4'h0);
        check("plan_after_rst", 32'(w_odata), 32'h6);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(79, 0) == 0) apply_reset("rnd");
            step(2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 4'($urandom_range(15, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
